// File: rtl/vgacon_buf_arbiter_if.sv
// Character-buffer access bundle: scanout fetch, CPU byte access,
// screen fill control and the starvation flag.
interface vgacon_buf_arbiter_if #(
  parameter int AW = 7
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;

  logic          fill_start;
  logic [7:0]    fill_value;
  logic          fill_busy;

  logic          starve_flag;
  logic          starve_clr;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           fill_start, fill_value, starve_clr,
    input  vid_data, vid_valid, cpu_rdata, cpu_ack, fill_busy, starve_flag
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           fill_start, fill_value, starve_clr,
    output vid_data, vid_valid, cpu_rdata, cpu_ack, fill_busy, starve_flag
  );
endinterface

// File: rtl/vgacon_buf_arbiter.sv
// VGA console character buffer: single-port byte RAM shared by scanout,
// CPU and the fill sequencer. Scanout wins unless the CPU side has waited
// MAX_WAIT cycles, in which case the scanout fetch is dropped and flagged.
//
// state | meaning
// IDLE  | CPU request or fill start may be accepted
// ACK   | CPU access completes, cpu_ack high, cpu_req ignored
// FILL  | fill sequencer writes one cell per granted slot
module vgacon_buf_arbiter #(
  parameter int DEPTH    = 96,
  parameter int AW       = 7,
  parameter int MAX_WAIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  vgacon_buf_arbiter_if.slave  bus_if
);

  typedef enum logic [1:0] {IDLE, ACK, FILL} state_e;

  state_e        state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [7:0]    fill_val_q, fill_val_d;
  logic          starve_q, starve_d;
  logic          vid_valid_q;
  logic [7:0]    vid_data_q;
  logic [7:0]    cpu_rdata_q;
  logic [7:0]    mem_q [DEPTH];

  logic          fill_acc;
  logic          cpu_pend;
  logic          forced;
  logic          vid_gnt;
  logic          fill_gnt;
  logic          cpu_gnt;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic          in_range;
  logic [7:0]    rd_byte;

  // Arbitration, RAM port mux and next-state logic.
  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    fill_val_d = fill_val_q;
    wait_cnt_d = wait_cnt_q;
    starve_d   = starve_q;

    // A fill start beats a simultaneous CPU request, so it also blocks the forced grant.
    fill_acc = (state_q == IDLE) && bus_if.fill_start;
    cpu_pend = (state_q == FILL) || ((state_q == IDLE) && bus_if.cpu_req);
    forced   = cpu_pend && !fill_acc && (wait_cnt_q == 8'(MAX_WAIT));
    vid_gnt  = bus_if.vid_req && !forced;
    fill_gnt = (state_q == FILL) && !vid_gnt;
    cpu_gnt  = (state_q == IDLE) && bus_if.cpu_req && !fill_acc && !vid_gnt;

    if (vid_gnt)       ram_addr = bus_if.vid_addr;
    else if (fill_gnt) ram_addr = fill_ptr_q;
    else               ram_addr = bus_if.cpu_addr;

    in_range  = ({1'b0, ram_addr} < (AW+1)'(DEPTH));
    ram_wdata = fill_gnt ? fill_val_q : bus_if.cpu_wdata;
    // No writes land on a reset cycle so an aborted fill stops cleanly.
    ram_we    = !rst_i && in_range && (fill_gnt || (cpu_gnt && bus_if.cpu_we));
    rd_byte   = in_range ? mem_q[ram_addr] : 8'h00;

    if (!cpu_pend || fill_gnt || cpu_gnt) wait_cnt_d = 8'h00;
    else                                  wait_cnt_d = wait_cnt_q + 8'h01;

    if (forced && bus_if.vid_req) starve_d = 1'b1;
    else if (bus_if.starve_clr)   starve_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fill_acc) begin
          state_d    = FILL;
          fill_ptr_d = '0;
          fill_val_d = bus_if.fill_value;
        end else if (cpu_gnt) begin
          state_d = ACK;
        end
      end
      ACK: state_d = IDLE;
      FILL: begin
        if (fill_gnt) begin
          fill_ptr_d = fill_ptr_q + 1'b1;
          if (fill_ptr_q == AW'(DEPTH-1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'h00;
      fill_ptr_q <= '0;
      fill_val_q <= 8'h00;
      starve_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fill_ptr_q <= fill_ptr_d;
      fill_val_q <= fill_val_d;
      starve_q   <= starve_d;
    end
  end

  // Read-data registers; each holds its last byte between accesses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vid_valid_q <= 1'b0;
      vid_data_q  <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      vid_valid_q <= vid_gnt;
      if (vid_gnt) vid_data_q <= rd_byte;
      if (cpu_gnt && !bus_if.cpu_we) cpu_rdata_q <= rd_byte;
    end
  end

  // Buffer RAM; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) mem_q[ram_addr] <= ram_wdata;
  end

  assign bus_if.vid_valid   = vid_valid_q;
  assign bus_if.vid_data    = vid_data_q;
  assign bus_if.cpu_rdata   = cpu_rdata_q;
  assign bus_if.cpu_ack     = (state_q == ACK);
  assign bus_if.fill_busy   = (state_q == FILL);
  assign bus_if.starve_flag = starve_q;

endmodule

// File: tb/tb_vgacon_buf_arbiter.sv
// Directed bench for vgacon_buf_arbiter with a scoreboard monitor on the
// vid_valid / cpu_ack outputs.
module tb_vgacon_buf_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vgacon_buf_arbiter_if #(.AW(7)) bus_if ();

  vgacon_buf_arbiter #(.DEPTH(96), .AW(7), .MAX_WAIT(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] vid_exp_q [$];
  logic [8:0] cpu_exp_q [$];   // {is_read, expected rdata}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents data.
  initial begin
    logic [7:0] ve;
    logic [8:0] ce;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_if.vid_valid) begin
          chk("vid_expected", 32'(vid_exp_q.size() != 0), 32'd1);
          if (vid_exp_q.size() != 0) begin
            ve = vid_exp_q.pop_front();
            chk("vid_data", 32'(bus_if.vid_data), 32'(ve));
          end
        end
        if (bus_if.cpu_ack) begin
          chk("cpu_expected", 32'(cpu_exp_q.size() != 0), 32'd1);
          if (cpu_exp_q.size() != 0) begin
            ce = cpu_exp_q.pop_front();
            if (ce[8]) chk("cpu_rdata", 32'(bus_if.cpu_rdata), 32'(ce[7:0]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Starts and ends on a falling edge; lat = falling edges from request to ack.
  task automatic cpu_op(input logic we, input logic [6:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp, output int lat);
    bus_if.cpu_req   = 1'b1;
    bus_if.cpu_we    = we;
    bus_if.cpu_addr  = addr;
    bus_if.cpu_wdata = wd;
    cpu_exp_q.push_back({~we, exp});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_if.cpu_ack && lat < 60);
    chk("cpu_acked", 32'(bus_if.cpu_ack), 32'd1);
    bus_if.cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_ack_pulse", 32'(bus_if.cpu_ack), 32'd0);
  endtask

  task automatic vid_read(input logic [6:0] addr, input logic [7:0] exp);
    bus_if.vid_req  = 1'b1;
    bus_if.vid_addr = addr;
    vid_exp_q.push_back(exp);
    @(negedge clk);
    bus_if.vid_req = 1'b0;
    chk("vid_valid_next", 32'(bus_if.vid_valid), 32'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_vid_valid",   32'(bus_if.vid_valid),   32'd0);
    chk("rst_vid_data",    32'(bus_if.vid_data),    32'd0);
    chk("rst_cpu_ack",     32'(bus_if.cpu_ack),     32'd0);
    chk("rst_cpu_rdata",   32'(bus_if.cpu_rdata),   32'd0);
    chk("rst_fill_busy",   32'(bus_if.fill_busy),   32'd0);
    chk("rst_starve_flag", 32'(bus_if.starve_flag), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int c;
    int n_busy;
    int fall_cyc;
    int ack_cyc;

    bus_if.vid_req    = 1'b0;
    bus_if.vid_addr   = '0;
    bus_if.cpu_req    = 1'b0;
    bus_if.cpu_we     = 1'b0;
    bus_if.cpu_addr   = '0;
    bus_if.cpu_wdata  = 8'h00;
    bus_if.fill_start = 1'b0;
    bus_if.fill_value = 8'h00;
    bus_if.starve_clr = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Fill with spaces, no video traffic.
    bus_if.fill_start = 1'b1;
    bus_if.fill_value = 8'h20;
    @(negedge clk);
    bus_if.fill_start = 1'b0;
    n = 0;
    while (bus_if.fill_busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("fill_busy_cycles", 32'(n), 32'd96);
    cpu_op(1'b0, 7'd0, 8'h00, 8'h20, lat);
    chk("cpu_read_latency", 32'(lat), 32'd1);
    cpu_op(1'b0, 7'd95, 8'h00, 8'h20, lat);
    chk("cpu_read_latency_95", 32'(lat), 32'd1);

    // CPU write then scanout fetch of the same cell.
    cpu_op(1'b1, 7'd5, 8'h41, 8'h00, lat);
    chk("cpu_write_latency", 32'(lat), 32'd1);
    vid_read(7'd5, 8'h41);

    // Continuous scanout against a held CPU read: forced grant on the 9th cycle.
    bus_if.vid_req  = 1'b1;
    bus_if.vid_addr = 7'd5;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 7'd3;
    repeat (8) vid_exp_q.push_back(8'h41);
    cpu_exp_q.push_back({1'b1, 8'h20});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.cpu_ack && n < 60);
    chk("starve_grant_cycle", 32'(n), 32'd9);
    chk("starve_vid_dropped", 32'(bus_if.vid_valid), 32'd0);
    chk("starve_flag_set", 32'(bus_if.starve_flag), 32'd1);
    bus_if.vid_req = 1'b0;
    bus_if.cpu_req = 1'b0;
    @(negedge clk);
    chk("starve_flag_sticky", 32'(bus_if.starve_flag), 32'd1);
    bus_if.starve_clr = 1'b1;
    @(negedge clk);
    bus_if.starve_clr = 1'b0;
    chk("starve_flag_clr", 32'(bus_if.starve_flag), 32'd0);

    // Out-of-range accesses.
    cpu_op(1'b1, 7'd100, 8'hFF, 8'h00, lat);
    cpu_op(1'b0, 7'd100, 8'h00, 8'h00, lat);
    cpu_op(1'b0, 7'd4,   8'h00, 8'h20, lat);
    cpu_op(1'b0, 7'd36,  8'h00, 8'h20, lat);
    vid_read(7'd127, 8'h00);
    vid_read(7'd5,   8'h41);

    // Fill of '.' aborted by reset after 40 cells.
    bus_if.fill_start = 1'b1;
    bus_if.fill_value = 8'h2E;
    @(negedge clk);
    bus_if.fill_start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    cpu_op(1'b0, 7'd0,  8'h00, 8'h2E, lat);
    cpu_op(1'b0, 7'd39, 8'h00, 8'h2E, lat);
    cpu_op(1'b0, 7'd40, 8'h00, 8'h20, lat);

    // Second fill_start during FILL is ignored; held CPU read waits for IDLE.
    bus_if.fill_start = 1'b1;
    bus_if.fill_value = 8'h55;
    @(negedge clk);
    bus_if.fill_start = 1'b0;
    bus_if.cpu_req    = 1'b1;
    bus_if.cpu_we     = 1'b0;
    bus_if.cpu_addr   = 7'd10;
    cpu_exp_q.push_back({1'b1, 8'h55});
    c = 1;
    n_busy = 0;
    fall_cyc = 0;
    ack_cyc = 0;
    while (c < 400 && ack_cyc == 0) begin
      if (bus_if.fill_busy) n_busy++;
      else if (fall_cyc == 0) fall_cyc = c;
      if (bus_if.cpu_ack) ack_cyc = c;
      if (c == 3) begin
        bus_if.fill_start = 1'b1;
        bus_if.fill_value = 8'h66;
      end
      if (c == 4) bus_if.fill_start = 1'b0;
      if (ack_cyc == 0) begin
        @(negedge clk);
        c++;
      end
    end
    bus_if.cpu_req = 1'b0;
    chk("refill_busy_cycles", 32'(n_busy), 32'd96);
    chk("refill_fall_cycle", 32'(fall_cyc), 32'd97);
    chk("refill_ack_cycle", 32'(ack_cyc), 32'd98);
    @(negedge clk);
    cpu_op(1'b0, 7'd95, 8'h00, 8'h55, lat);

    repeat (3) @(negedge clk);
    chk("vid_scoreboard_drained", 32'(vid_exp_q.size()), 32'd0);
    chk("cpu_scoreboard_drained", 32'(cpu_exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
